popcount_vec_accumulator: RTL



---
 rtl/popcount_vec_accumulator_pkg.sv | 21 ++
 rtl/popcount_vec_accumulator.sv | 117 +++++++++++
 2 files changed

// File: rtl/popcount_vec_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// popcount_vec_accumulator_pkg
//
// Shared configuration for the vector popcount accumulator. These constants
// sit next to the adder-tree configuration: CFG_BEATS is the number of tree
// beats per vector, CFG_IN_MAX the largest value one tree beat can carry, and
// CFG_VEC_POPCOUNT_WIDTH the width of a full vector popcount.
// -----------------------------------------------------------------------------
package popcount_vec_accumulator_pkg;

    localparam int CFG_BEATS  = 4;
    localparam int CFG_IN_MAX = 64;

    // Width able to hold the largest vector popcount (BEATS * IN_MAX).
    function automatic int vec_popcount_width(input int beats, input int in_max);
        return $clog2(beats * in_max + 1);
    endfunction

    localparam int CFG_VEC_POPCOUNT_WIDTH = vec_popcount_width(CFG_BEATS, CFG_IN_MAX);

endpackage

// File: rtl/popcount_vec_accumulator.sv
// -----------------------------------------------------------------------------
// popcount_vec_accumulator
//
// Accepts partial popcount beats from the adder tree and sums up to BEATS of
// them (fewer if in_last arrives early) into one vector popcount, presented
// on a single-entry output slot. A sticky err_len flags vectors whose in_last
// marker disagrees with the expected length.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. valid never waits for ready; in_ready never depends on in_valid.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_sum       partial sum from the adder tree (IN_W bits)
//   in_last      final beat of the current vector
//   in_valid     beat valid
//   in_ready     beat accepted when in_valid & in_ready
//   vec_sum      accumulated vector popcount (OUT_W bits)
//   vec_beats    number of beats in the emitted vector, 1..BEATS
//   out_valid    result valid
//   out_ready    result consumed when out_valid & out_ready
//   err_len      sticky vector-length error
//   clr_err      synchronous clear of err_len (a same-cycle set wins)
// -----------------------------------------------------------------------------
module popcount_vec_accumulator
    import popcount_vec_accumulator_pkg::*;
#(
    parameter int BEATS  = CFG_BEATS,
    parameter int IN_MAX = CFG_IN_MAX,
    parameter int IN_W   = $clog2(IN_MAX + 1),
    parameter int OUT_W  = $clog2(BEATS * IN_MAX + 1),
    parameter int CNT_W  = $clog2(BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] vec_sum,
    output logic [CNT_W-1:0] vec_beats,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_len,
    input  logic             clr_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [OUT_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             at_full_len;
    logic             closing;
    logic             slot_stalled;
    logic             accept;
    logic             len_mismatch;
    logic [OUT_W-1:0] acc_next;

    // With BEATS == 1 the counter never leaves 0, so every beat is full length.
    assign at_full_len  = (cnt == LAST_CNT);
    assign closing      = in_last | at_full_len;
    assign slot_stalled = out_valid & ~out_ready;

    // Only the closing beat needs the output slot, so non-closing beats keep
    // flowing into the accumulator even while the result is held.
    assign in_ready     = ~slot_stalled | ~closing;
    assign accept       = in_valid & in_ready;

    // A vector closed by in_last short of BEATS, or forced closed at BEATS
    // without in_last, has the wrong length.
    assign len_mismatch = in_last ^ at_full_len;

    assign acc_next     = acc + OUT_W'(in_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (closing) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_next;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output slot: loading a new result takes priority over draining, which
    // allows a handshake and a fresh load in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_sum   <= '0;
            vec_beats <= '0;
            out_valid <= 1'b0;
        end else if (accept && closing) begin
            vec_sum   <= acc_next;
            vec_beats <= cnt + CNT_W'(1);
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len <= 1'b0;
        end else if (accept && closing && len_mismatch) begin
            err_len <= 1'b1;
        end else if (clr_err) begin
            err_len <= 1'b0;
        end
    end

endmodule
